// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
//   Bundles the two requester ports and the memory-side bus of the
//   data memory arbiter.
//   Requester side (per port n = 0/1):
//     reqN, weN, addrN[7:0], wdataN[31:0], beN[3:0]  -> arbiter
//     ackN, rdataN[31:0]                             <- arbiter
//   Memory side:
//     mem_we, mem_addr[7:0], mem_wd[31:0]            <- arbiter
//     mem_rd[31:0]                                   -> arbiter
//   Status:
//     busy                                           <- arbiter
//   slave  : the arbiter's view
//   master : the surrounding system's view (requesters + memory)
interface data_mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        busy;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1,
               wdata0, wdata1, be0, be1, mem_rd,
        output ack0, ack1, rdata0, rdata1, busy,
               mem_we, mem_addr, mem_wd
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1,
               wdata0, wdata1, be0, be1, mem_rd,
        input  ack0, ack1, rdata0, rdata1, busy,
               mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Round-robin two-port arbiter and access sequencer for a single-ported
//   256-byte data memory (32-bit words, combinational read, synchronous
//   write). Partial-word stores are done as read-modify-write.
//   Ports:
//     clk  : system clock, all state changes on posedge
//     rst  : asynchronous reset, active low
//     bus  : data_mem_arbiter_if.slave (requester ports, memory bus, busy)
module data_mem_arbiter (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_last_grant;
    logic        r_id;
    logic        r_we;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_merge;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic [7:0]  r_mem_addr;
    logic [31:0] r_mem_wd;

    logic        w_grant;
    logic        w_grant_id;
    logic        w_full;
    logic        w_none;
    logic        w_mem_we;
    logic [7:0]  w_mem_addr;
    logic [31:0] w_mem_wd;
    logic [31:0] w_merge;

    // On a tie the port that was not granted last wins.
    assign w_grant    = bus.req0 | bus.req1;
    assign w_grant_id = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;

    assign w_full = (r_be == 4'hF);
    assign w_none = (r_be == 4'h0);

    always_comb begin
        w_merge = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_merge[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : bus.mem_rd[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory address/data fall back to the hold registers outside the
    // access states, so they keep their last driven value.
    always_comb begin
        w_next     = r_state;
        w_mem_we   = 1'b0;
        w_mem_addr = r_mem_addr;
        w_mem_wd   = r_mem_wd;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_mem_addr = r_addr;
                if (r_we && w_full) begin
                    w_mem_we = 1'b1;
                    w_mem_wd = r_wdata;
                    w_next   = S_ACK;
                end else if (r_we && !w_none) begin
                    w_next = S_WRITE;
                end else begin
                    w_next = S_ACK;
                end
            end
            S_WRITE: begin
                w_mem_addr = r_addr;
                w_mem_we   = 1'b1;
                w_mem_wd   = r_merge;
                w_next     = S_ACK;
            end
            S_ACK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_merge      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
        end else begin
            r_mem_addr <= w_mem_addr;
            r_mem_wd   <= w_mem_wd;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_id    <= w_grant_id;
                        r_we    <= w_grant_id ? bus.we1    : bus.we0;
                        r_addr  <= w_grant_id ? bus.addr1  : bus.addr0;
                        r_wdata <= w_grant_id ? bus.wdata1 : bus.wdata0;
                        r_be    <= w_grant_id ? bus.be1    : bus.be0;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        if (r_id) begin
                            r_rdata1 <= bus.mem_rd;
                        end else begin
                            r_rdata0 <= bus.mem_rd;
                        end
                    end else if (!w_full && !w_none) begin
                        r_merge <= w_merge;
                    end
                end
                S_ACK: begin
                    r_last_grant <= r_id;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ack0     = (r_state == S_ACK) && !r_id;
    assign bus.ack1     = (r_state == S_ACK) &&  r_id;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
    assign bus.mem_we   = w_mem_we;
    assign bus.mem_addr = w_mem_addr;
    assign bus.mem_wd   = w_mem_wd;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    logic clk;
    logic rst;

    data_mem_arbiter_if bus ();

    data_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory fixture: combinational read, synchronous write, plus a
    // backdoor port used only to preload contents.
    logic [31:0] mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    assign bus.mem_rd = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wd;
        end
    end

    typedef struct {
        int          port;
        int          lat;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [0:63];
    logic [31:0] rd_model [0:1];
    int          tb_last;
    int          n_err;
    int          n_chk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic we, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.be0 = be;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.be1 = be;
        end
    endtask

    // Single transaction on one port, started just after a negedge.
    task automatic run_txn(input string nm, input int p, input logic we, input logic [7:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        exp_t        e;
        int          we_cnt;
        int          we_cyc;
        int          c;
        bit          got;
        int          idx;
        logic [31:0] old_w;
        logic [31:0] new_w;
        we_cnt = 0;
        we_cyc = 0;
        got    = 0;
        idx    = int'(a[7:2]);
        old_w  = model[idx];
        new_w  = old_w;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
            end
        end
        e.port  = p;
        e.lat   = (we && be != 4'hF && be != 4'h0) ? 3 : 2;
        e.rdata = we ? rd_model[p] : old_w;
        sb.push_back(e);
        drive(p, 1'b1, we, a, wd, be);
        for (c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
            if (bus.mem_we) begin
                we_cnt++;
                we_cyc = c;
            end
            if (bus.ack0 || bus.ack1) chk({nm, "_ack_excl"}, 32'(bus.ack0 & bus.ack1), 32'd0);
            if ((p == 0) ? bus.ack0 : bus.ack1) begin
                got = 1;
                break;
            end
        end
        drive(p, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        e = sb.pop_front();
        chk({nm, "_ack_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(c), 32'(e.lat));
        chk({nm, "_rdata_own"}, (p == 0) ? bus.rdata0 : bus.rdata1, e.rdata);
        chk({nm, "_rdata_other"}, (p == 0) ? bus.rdata1 : bus.rdata0, rd_model[1-p]);
        chk({nm, "_we_count"}, 32'(we_cnt), (we && be != 4'h0) ? 32'd1 : 32'd0);
        if (e.lat == 3) chk({nm, "_we_in_write"}, 32'(we_cyc), 32'd2);
        if (!we) rd_model[p] = old_w;
        model[idx] = new_w;
        tb_last = p;
        @(negedge clk);
        chk({nm, "_ack_pulse"}, 32'({bus.ack1, bus.ack0}), 32'd0);
        chk({nm, "_idle"}, 32'(bus.busy), 32'd0);
        chk({nm, "_mem_word"}, mem[idx], model[idx]);
    endtask

    // Both ports reading continuously; four grants must alternate.
    task automatic run_both(input string nm, input logic [7:0] a0, input logic [7:0] a1);
        exp_t e;
        int   nack;
        int   prev;
        int   port;
        int   first;
        nack  = 0;
        prev  = 0;
        first = (tb_last == 1) ? 0 : 1;
        for (int k = 0; k < 4; k++) begin
            e.port  = (k % 2 == 0) ? first : 1 - first;
            e.lat   = 3;
            e.rdata = (e.port == 0) ? model[a0[7:2]] : model[a1[7:2]];
            sb.push_back(e);
        end
        drive(0, 1'b1, 1'b0, a0, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, a1, 32'h0, 4'h0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.mem_we) chk({nm, "_no_we"}, 32'(bus.mem_we), 32'd0);
            if (bus.ack0 || bus.ack1) begin
                chk({nm, "_ack_excl"}, 32'(bus.ack0 & bus.ack1), 32'd0);
                port = bus.ack1 ? 1 : 0;
                e = sb.pop_front();
                chk({nm, "_order"}, 32'(port), 32'(e.port));
                chk({nm, "_rdata"}, (port == 0) ? bus.rdata0 : bus.rdata1, e.rdata);
                chk({nm, "_gap"}, 32'(c - prev), (nack == 0) ? 32'd2 : 32'd3);
                rd_model[port] = e.rdata;
                tb_last = port;
                prev = c;
                nack++;
                if (nack == 4) break;
            end
        end
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        chk({nm, "_ack_total"}, 32'(nack), 32'd4);
        sb.delete();
        @(negedge clk);
        chk({nm, "_idle"}, 32'({bus.busy, bus.ack1, bus.ack0}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err = 0;
        n_chk = 0;
        tb_last = 1;
        rd_model[0] = '0;
        rd_model[1] = '0;
        rst = 1'b0;
        bd_we = 1'b0;
        bd_idx = '0;
        bd_data = '0;
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

        // Preload while held in reset.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_idx  = 6'(i);
            bd_data = {8'(i), 8'h5A, ~8'(i), 8'hC3};
            if (i == 3)  bd_data = 32'hDEADBEEF;
            if (i == 4)  bd_data = 32'hAABBCCDD;
            if (i == 8)  bd_data = 32'h0BADF00D;
            if (i == 12) bd_data = 32'h01234567;
            model[i] = bd_data;
        end
        @(negedge clk);
        bd_we = 1'b0;

        chk("rst_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wd", bus.mem_wd, 32'd0);
        chk("rst_rdata0", bus.rdata0, 32'd0);
        chk("rst_rdata1", bus.rdata1, 32'd0);

        rst = 1'b1;
        @(negedge clk);

        run_txn("rd0", 0, 1'b0, 8'h0C, 32'h0, 4'h0);
        chk("rd0_value", bus.rdata0, 32'hDEADBEEF);

        run_txn("fw1", 1, 1'b1, 8'h40, 32'h12345678, 4'hF);
        run_txn("fw1_rb", 1, 1'b0, 8'h40, 32'h0, 4'h0);
        chk("fw1_value", bus.rdata1, 32'h12345678);
        chk("fw1_rdata0_kept", bus.rdata0, 32'hDEADBEEF);

        run_txn("pw0", 0, 1'b1, 8'h10, 32'h00001100, 4'b0010);
        run_txn("pw0_rb", 0, 1'b0, 8'h10, 32'h0, 4'h0);
        chk("pw0_value", bus.rdata0, 32'hAABB11DD);

        run_txn("both_a", 0, 1'b0, 8'h0C, 32'h0, 4'h0);
        run_both("both", 8'h0C, 8'h40);

        run_txn("be0", 1, 1'b1, 8'h20, 32'hFFFFFFFF, 4'h0);
        run_txn("mis", 1, 1'b0, 8'h23, 32'h0, 4'h0);
        chk("mis_value", bus.rdata1, 32'h0BADF00D);

        run_txn("pw1", 1, 1'b1, 8'h31, 32'hA5000000, 4'b1000);

        // Reset while the partial write sits in WRITE.
        drive(0, 1'b1, 1'b1, 8'h30, 32'h0000EE00, 4'b0010);
        @(negedge clk);
        @(negedge clk);
        chk("rmid_in_write", 32'(bus.mem_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("rmid_we_off", 32'(bus.mem_we), 32'd0);
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_mem_addr", 32'(bus.mem_addr), 32'd0);
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rmid_no_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
        end
        chk("rmid_word_kept", mem[12], model[12]);
        chk("rmid_rdata0", bus.rdata0, 32'd0);
        chk("rmid_rdata1", bus.rdata1, 32'd0);
        rd_model[0] = '0;
        rd_model[1] = '0;
        tb_last = 1;
        rst = 1'b1;
        @(negedge clk);
        run_both("post_rst", 8'h04, 8'h30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
